coin_credit_controller: RTL and testbench
=========================================

Name: coin_credit_controller

Overview:
Vending-machine credit controller that sits downstream of the coin detector. It turns the detector's dime/nickel/quarter outputs into a cents credit register. It handles vend and coin-return requests, and dispenses change one coin at a time over a request/acknowledge handshake to the coin dispenser.

Parameters:
PRICE, 65, item price in cents; must be a multiple of 5 and no larger than CREDIT_MAX
CREDIT_MAX, 100, maximum credit in cents; any coin that would exceed it is rejected
CREDIT_W, 8, credit register width; 2**CREDIT_W-1 must be at least CREDIT_MAX+25

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
dimeDetected  input  1  coin detector dime output (level, already synchronous to clk)
nickelDetected  input  1  coin detector nickel output
quarterDetected  input  1  coin detector quarter output
vendReq  input  1  customer vend button (level, synchronous)
returnReq  input  1  customer coin-return button (level, synchronous)
changeAck  input  1  dispenser: one coin has been released
credit  output  CREDIT_W  current credit in cents
vendPulse  output  1  one-cycle pulse that releases the item
coinReject  output  1  one-cycle pulse that routes the inserted coin to the return chute
changeNickel  output  1  request dispenser to release a nickel
changeDime  output  1  request dispenser to release a dime (only active with DIME_CHANGE_EN)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, asserted): state=IDLE, credit=0, all pulse and request outputs 0, edge-detect registers 0. Reset mid-vend or mid-change abandons the operation and the credit is lost.
- Coin event: the rising edge of a detector input (input=1 and its registered previous value=0). Value is 10, 5 or 25 cents.
- Exactly one rising edge in a cycle is a valid event. Two or more simultaneous rising edges: no credit, coinReject pulses once.
- IDLE, valid event:
  - If credit+value <= CREDIT_MAX, credit updates on the next clk edge (1-cycle latency from the input first seen high).
  - Otherwise credit is unchanged and coinReject is high for that following cycle.
- IDLE, vendReq=1 and credit >= PRICE:
  - Go to VEND, credit -= PRICE.
  - vendReq has priority over returnReq.
  - vendReq with credit < PRICE is ignored.
- IDLE, returnReq=1 and credit>0: go to CHANGE (refund the whole credit).
- VEND: vendPulse=1 for exactly one cycle. Next state is CHANGE if credit>0, else IDLE.
- CHANGE:
  - Hold changeNickel=1 until the cycle in which changeAck=1; in that cycle credit -= 5.
  - Drop the request for one cycle (GAP state) before the next coin.
  - From GAP: credit==0 goes to IDLE, otherwise back to CHANGE.
  - changeAck outside CHANGE is ignored.
- Coin event while busy: never credited; coinReject pulses one cycle.
- vendReq/returnReq while busy: ignored. They are level-sampled, so a held button re-triggers after returning to IDLE; this is intended.
- credit never wraps: the add is bounded by the CREDIT_MAX check, and the subtract by the state guards.

Optional Feature:
DIME_CHANGE_EN:
- Defined: in CHANGE, request changeDime while credit >= 10, otherwise changeNickel. On ack, subtract 10 or 5 accordingly. Only one request is high at a time.
- Undefined: nickels only; changeDime tied 0.

Decomposition:
- Package coin_pkg holds:
  - constants NICKEL_CENTS=5, DIME_CENTS=10, QUARTER_CENTS=25
  - enum ctrl_state_t {IDLE, VEND, CHANGE, GAP}
- One sub-module, coin_edge_detect: registers the three detector inputs and outputs coinValid, coinMulti and coinValue[4:0].

Test Plan:
1. Reset, insert quarter, quarter, dime, nickel (one at a time) → credit 25, 50, 60, 65; then vendReq → vendPulse once, credit 0, no change requests, back to IDLE.
2. Credit 75, vendReq → vendPulse, credit 10; changeAck after 3 cycles each → two changeNickel handshakes, credit 5 then 0, IDLE. With DIME_CHANGE_EN: one changeDime handshake.
3. Credit 90, insert quarter → coinReject 1 cycle, credit stays 90; insert dime → credit 100.
4. Credit 40, returnReq → 8 nickel handshakes, credit 0; a dime inserted mid-refund → coinReject, credit unaffected.
5. dimeDetected and quarterDetected rise in the same cycle → coinReject, credit unchanged; vendReq with credit 60 → no vendPulse.
6. Assert reset while in CHANGE with credit 15 → outputs 0 immediately (asynchronously), credit 0, state IDLE after release.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin values and controller state encoding for the coin credit controller.
package coin_pkg;

  localparam int NICKEL_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;

  typedef enum logic [1:0] {
    IDLE,
    VEND,
    CHANGE,
    GAP
  } ctrl_state_t;

endpackage

// File: rtl/coin_edge_detect.sv
// Rising-edge detector for the three coin detector outputs; flags a single coin
// (with its value in cents) or a simultaneous multi-coin event.
module coin_edge_detect
  import coin_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dimeDetected,
  input  logic       nickelDetected,
  input  logic       quarterDetected,
  output logic       coinValid,
  output logic       coinMulti,
  output logic [4:0] coinValue
);

  logic [2:0] prev_reg;
  logic [2:0] level;
  logic [2:0] rise;

  // bit 0 nickel, bit 1 dime, bit 2 quarter
  assign level = {quarterDetected, dimeDetected, nickelDetected};
  assign rise  = level & ~prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_reg <= 3'b000;
    else       prev_reg <= level;
  end

  assign coinMulti = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
  assign coinValid = (|rise) & ~coinMulti;

  always_comb begin
    coinValue = 5'd0;
    case (rise)
      3'b001:  coinValue = 5'(NICKEL_CENTS);
      3'b010:  coinValue = 5'(DIME_CENTS);
      3'b100:  coinValue = 5'(QUARTER_CENTS);
      default: coinValue = 5'd0;
    endcase
  end

endmodule

// File: rtl/coin_credit_controller.sv
// Vending credit controller: accumulates coins, vends, and pays change over a req/ack
// handshake. Define DIME_CHANGE_EN to pay change in dimes where possible.
module coin_credit_controller
  import coin_pkg::*;
#(
  parameter int unsigned PRICE      = 65,
  parameter int unsigned CREDIT_MAX = 100,
  parameter int unsigned CREDIT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dimeDetected,
  input  logic                nickelDetected,
  input  logic                quarterDetected,
  input  logic                vendReq,
  input  logic                returnReq,
  input  logic                changeAck,
  output logic [CREDIT_W-1:0] credit,
  output logic                vendPulse,
  output logic                coinReject,
  output logic                changeNickel,
  output logic                changeDime,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(CREDIT_MAX);
  localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(NICKEL_CENTS);
  localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(DIME_CENTS);

  ctrl_state_t         state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic                reject_reg, reject_next;

  logic                coin_valid;
  logic                coin_multi;
  logic [4:0]          coin_value;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                use_dime;
  logic [CREDIT_W-1:0] change_cents;

  coin_edge_detect u_edge (
    .clk             (clk),
    .reset           (reset),
    .dimeDetected    (dimeDetected),
    .nickelDetected  (nickelDetected),
    .quarterDetected (quarterDetected),
    .coinValid       (coin_valid),
    .coinMulti       (coin_multi),
    .coinValue       (coin_value)
  );

  assign coin_sum  = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_value);
  assign coin_fits = (coin_sum <= MAX_C);

`ifdef DIME_CHANGE_EN
  assign use_dime = (credit_reg >= DIME_C);
`else
  assign use_dime = 1'b0;
`endif
  assign change_cents = use_dime ? DIME_C : NICKEL_C;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      credit_reg <= '0;
      reject_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      reject_reg <= reject_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    reject_next = 1'b0;

    if (coin_multi) reject_next = 1'b1;
    else if (coin_valid && (state_reg != IDLE || !coin_fits)) reject_next = 1'b1;

    case (state_reg)
      IDLE: begin
        // A coin landing in the same cycle as a vend/return is still credited;
        // the vend subtracts from the updated total and the refund pays it all.
        if (coin_valid && !coin_multi && coin_fits) credit_next = coin_sum[CREDIT_W-1:0];
        if (vendReq && credit_reg >= PRICE_C) begin
          state_next  = VEND;
          credit_next = credit_next - PRICE_C;
        end else if (returnReq && credit_reg != '0) begin
          state_next = CHANGE;
        end
      end
      VEND:   state_next = (credit_reg != '0) ? CHANGE : IDLE;
      CHANGE: begin
        if (changeAck) begin
          credit_next = credit_reg - change_cents;
          state_next  = GAP;
        end
      end
      GAP:     state_next = (credit_reg == '0) ? IDLE : CHANGE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    vendPulse    = (state_reg == VEND);
    changeNickel = (state_reg == CHANGE) && !use_dime;
    changeDime   = (state_reg == CHANGE) && use_dime;
    busy         = (state_reg != IDLE);
  end

  assign credit     = credit_reg;
  assign coinReject = reject_reg;

endmodule

// File: tb/tb_coin_credit_controller.sv
// Self-checking bench for coin_credit_controller: directed scenarios plus a randomized
// transaction sequence checked against a cents-level model.
module tb_coin_credit_controller;

  localparam int PRICE      = 65;
  localparam int CREDIT_MAX = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dimeDetected = 1'b0;
  logic       nickelDetected = 1'b0;
  logic       quarterDetected = 1'b0;
  logic       vendReq = 1'b0;
  logic       returnReq = 1'b0;
  logic       changeAck = 1'b0;
  logic [7:0] credit;
  logic       vendPulse;
  logic       coinReject;
  logic       changeNickel;
  logic       changeDime;
  logic       busy;

  int errors = 0;
  int checks = 0;

  coin_credit_controller dut (
    .clk             (clk),
    .reset           (reset),
    .dimeDetected    (dimeDetected),
    .nickelDetected  (nickelDetected),
    .quarterDetected (quarterDetected),
    .vendReq         (vendReq),
    .returnReq       (returnReq),
    .changeAck       (changeAck),
    .credit          (credit),
    .vendPulse       (vendPulse),
    .coinReject      (coinReject),
    .changeNickel    (changeNickel),
    .changeDime      (changeDime),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Coin counts the dispenser should see for a given amount of change.
  task automatic expected_coins(input int cents, output int nickels, output int dimes);
`ifdef DIME_CHANGE_EN
    dimes   = cents / 10;
    nickels = (cents % 10) / 5;
`else
    dimes   = 0;
    nickels = cents / 5;
`endif
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // kind: 0 nickel, 1 dime, 2 quarter, 3 dime+quarter, 4 all three
  task automatic insert_coin(input int kind, output int rejects);
    rejects = 0;
    @(posedge clk); #1;
    nickelDetected  = (kind == 0) || (kind == 4);
    dimeDetected    = (kind == 1) || (kind == 3) || (kind == 4);
    quarterDetected = (kind == 2) || (kind == 3) || (kind == 4);
    @(posedge clk); #1;
    nickelDetected = 1'b0; dimeDetected = 1'b0; quarterDetected = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (coinReject) rejects++;
    end
  endtask

  // Press vend or return for one cycle, then act as the dispenser until idle.
  task automatic run_request(input bit use_return, input int ack_delay, input int inject,
                             output int vends, output int nickels, output int dimes,
                             output int rejects, output bit timed_out, output bit overlap);
    int  wait_cnt;
    int  delay;
    bit  done;
    vends = 0; nickels = 0; dimes = 0; rejects = 0; overlap = 0; done = 0;
    wait_cnt = 0;
    delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
    @(posedge clk); #1;
    if (use_return) returnReq = 1'b1; else vendReq = 1'b1;
    @(posedge clk); #1;
    vendReq = 1'b0; returnReq = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (vendPulse) vends++;
      if (coinReject) rejects++;
      if (changeNickel && changeDime) overlap = 1;
      if (c == inject) dimeDetected = 1'b1;
      if (c == inject + 2) dimeDetected = 1'b0;
      if (!busy && c > inject + 4) done = 1;
      else if (changeNickel || changeDime) begin
        if (wait_cnt >= delay) begin
          changeAck = 1'b1;
          if (changeDime) dimes++; else nickels++;
          wait_cnt = 0;
          delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk); #1;
      changeAck = 1'b0;
    end
    dimeDetected = 1'b0;
    timed_out = !done;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got=%0d exp=0", credit); end
    checks++; if ({vendPulse, coinReject, changeNickel, changeDime, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=00000", {vendPulse, coinReject, changeNickel, changeDime, busy});
    end
    $display("test_reset: credit=%0d busy=%0b", credit, busy);
  endtask

  task automatic test_vend_exact();
    int rej, v, n, d, r, exp_credit[4];
    bit to, ov;
    int kinds[4];
    kinds = '{2, 2, 1, 0};
    exp_credit = '{25, 50, 60, 65};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      insert_coin(kinds[i], rej);
      checks++; if (int'(credit) !== exp_credit[i] || rej != 0) begin
        errors++; $display("FAIL vend_exact_coin%0d credit=%0d rej=%0d exp credit=%0d rej=0", i, credit, rej, exp_credit[i]);
      end
      $display("insert kind=%0d credit=%0d", kinds[i], credit);
    end
    run_request(0, 3, -10, v, n, d, r, to, ov);
    checks++; if (v != 1 || n != 0 || d != 0 || to || credit !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL vend_exact got vends=%0d n=%0d d=%0d credit=%0d busy=%0b to=%0b exp 1/0/0/0/0/0", v, n, d, credit, busy, to);
    end
    $display("vend exact: vends=%0d credit=%0d", v, credit);
  endtask

  task automatic test_vend_change();
    int rej, v, n, d, r, en, ed;
    bit to, ov;
    apply_reset();
    repeat (3) insert_coin(2, rej);
    checks++; if (credit !== 8'd75) begin errors++; $display("FAIL change_setup credit=%0d exp=75", credit); end
    run_request(0, 3, -10, v, n, d, r, to, ov);
    expected_coins(10, en, ed);
    checks++; if (v != 1 || n != en || d != ed || to || ov) begin
      errors++; $display("FAIL vend_change vends=%0d n=%0d d=%0d to=%0b ov=%0b exp vends=1 n=%0d d=%0d", v, n, d, to, ov, en, ed);
    end
    checks++; if (credit !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL vend_change_end credit=%0d busy=%0b exp 0/0", credit, busy);
    end
    $display("vend change: vends=%0d nickels=%0d dimes=%0d credit=%0d", v, n, d, credit);
  endtask

  task automatic test_overflow();
    int rej;
    int kinds[5];
    kinds = '{2, 2, 2, 1, 0};
    apply_reset();
    foreach (kinds[i]) insert_coin(kinds[i], rej);
    checks++; if (credit !== 8'd90) begin errors++; $display("FAIL overflow_setup credit=%0d exp=90", credit); end
    insert_coin(2, rej);
    checks++; if (credit !== 8'd90 || rej != 1) begin
      errors++; $display("FAIL overflow_reject credit=%0d rej=%0d exp 90/1", credit, rej);
    end
    insert_coin(1, rej);
    checks++; if (credit !== 8'd100 || rej != 0) begin
      errors++; $display("FAIL overflow_fill credit=%0d rej=%0d exp 100/0", credit, rej);
    end
    $display("overflow: credit=%0d", credit);
  endtask

  task automatic test_refund();
    int rej, v, n, d, r, en, ed;
    bit to, ov;
    apply_reset();
    insert_coin(2, rej); insert_coin(1, rej); insert_coin(0, rej);
    checks++; if (credit !== 8'd40) begin errors++; $display("FAIL refund_setup credit=%0d exp=40", credit); end
    run_request(1, -1, 4, v, n, d, r, to, ov);
    expected_coins(40, en, ed);
    checks++; if (v != 0 || n != en || d != ed || r != 1 || to || ov) begin
      errors++; $display("FAIL refund vends=%0d n=%0d d=%0d rej=%0d to=%0b ov=%0b exp 0/%0d/%0d/1", v, n, d, r, to, ov, en, ed);
    end
    checks++; if (credit !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL refund_end credit=%0d busy=%0b exp 0/0", credit, busy);
    end
    $display("refund: nickels=%0d dimes=%0d rejects=%0d credit=%0d", n, d, r, credit);
  endtask

  task automatic test_multi_coin();
    int rej, v, n, d, r;
    bit to, ov;
    apply_reset();
    insert_coin(2, rej); insert_coin(2, rej); insert_coin(1, rej);
    insert_coin(3, rej);
    checks++; if (credit !== 8'd60 || rej != 1) begin
      errors++; $display("FAIL multi_coin credit=%0d rej=%0d exp 60/1", credit, rej);
    end
    run_request(0, 0, -10, v, n, d, r, to, ov);
    checks++; if (v != 0 || credit !== 8'd60 || busy !== 1'b0) begin
      errors++; $display("FAIL vend_short vends=%0d credit=%0d busy=%0b exp 0/60/0", v, credit, busy);
    end
    $display("multi coin: credit=%0d vends=%0d", credit, v);
  endtask

  task automatic test_async_reset();
    int rej;
    bit seen;
    apply_reset();
    insert_coin(1, rej); insert_coin(0, rej);
    @(posedge clk); #1; returnReq = 1'b1;
    @(posedge clk); #1; returnReq = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (changeNickel || changeDime) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL async_setup change_request got=0 exp=1"); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({vendPulse, coinReject, changeNickel, changeDime, busy} !== 5'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL async_reset outputs=%b credit=%0d exp 00000/0",
                         {vendPulse, coinReject, changeNickel, changeDime, busy}, credit);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL async_release busy=%0b credit=%0d exp 0/0", busy, credit);
    end
    $display("async reset: busy=%0b credit=%0d", busy, credit);
  endtask

  task automatic test_random();
    int model, op, kind, val, rej, v, n, d, r, en, ed, change, exp_v;
    bit to, ov;
    apply_reset();
    model = 0;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 6));
      if (op <= 3) begin
        kind = int'($urandom_range(0, 2));
        val = (kind == 0) ? 5 : (kind == 1) ? 10 : 25;
        insert_coin(kind, rej);
        if (model + val <= CREDIT_MAX) begin
          model += val;
          checks++; if (rej != 0 || int'(credit) != model) begin
            errors++; $display("FAIL rand_coin%0d credit=%0d rej=%0d exp %0d/0", i, credit, rej, model);
          end
        end else begin
          checks++; if (rej != 1 || int'(credit) != model) begin
            errors++; $display("FAIL rand_coin%0d credit=%0d rej=%0d exp %0d/1", i, credit, rej, model);
          end
        end
        $display("rand %0d: coin %0d credit=%0d", i, val, credit);
      end else if (op == 4) begin
        insert_coin(int'($urandom_range(3, 4)), rej);
        checks++; if (rej != 1 || int'(credit) != model) begin
          errors++; $display("FAIL rand_multi%0d credit=%0d rej=%0d exp %0d/1", i, credit, rej, model);
        end
        $display("rand %0d: multi coin credit=%0d", i, credit);
      end else begin
        if (op == 5) begin
          exp_v = (model >= PRICE) ? 1 : 0;
          change = exp_v ? model - PRICE : 0;
          if (exp_v) model = 0;
        end else begin
          exp_v = 0;
          change = model;
          model = 0;
        end
        run_request(op == 6, -1, -10, v, n, d, r, to, ov);
        expected_coins(change, en, ed);
        checks++; if (v != exp_v || n != en || d != ed || to || ov || int'(credit) != model) begin
          errors++; $display("FAIL rand_req%0d vends=%0d n=%0d d=%0d credit=%0d to=%0b ov=%0b exp %0d/%0d/%0d/%0d",
                             i, v, n, d, credit, to, ov, exp_v, en, ed, model);
        end
        $display("rand %0d: %s vends=%0d nickels=%0d dimes=%0d credit=%0d",
                 i, (op == 6) ? "return" : "vend", v, n, d, credit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vend_exact();
    test_vend_change();
    test_overflow();
    test_refund();
    test_multi_coin();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
